sync_fifo_flags: RTL and testbench



---
 rtl/sync_fifo_flags_if.sv | 30 +++
 rtl/sync_fifo_flags.sv | 100 ++++++++++
 tb/tb_sync_fifo_flags.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle for sync_fifo_flags.
// The master side drives requests; the slave side (the FIFO) returns data and flags.
interface sync_fifo_flags_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             flush;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic             clr_err;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             almost_full;
  logic             almost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, winc, wdata, rinc, clr_err,
    input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, winc, wdata, rinc, clr_err,
    output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact fill count, programmable almost flags,
// FWFT or registered read, synchronous flush and sticky error flags.
module sync_fifo_flags #(
  parameter int DSIZE         = 8,
  parameter int ASIZE         = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_fifo_flags_if.slave  bus
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_THRESH);
  localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_THRESH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wptr, rptr;
  logic [ASIZE:0]   count_q, count_next;
  logic             wfull_q, rempty_q, afull_q, aempty_q;
  logic             ovf_q, unf_q;
  logic             wr_ok, rd_ok;

  // Acceptance looks only at the registered flags, so a read frees no room
  // for a same-cycle write at full and a write supplies no word at empty.
  always_comb begin
    wr_ok = bus.winc & ~wfull_q;
    rd_ok = bus.rinc & ~rempty_q;
    if (bus.flush)
      count_next = '0;
    else
      count_next = count_q + {{ASIZE{1'b0}}, wr_ok} - {{ASIZE{1'b0}}, rd_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      count_q  <= count_next;
      wfull_q  <= (count_next == DEPTH_C);
      rempty_q <= (count_next == '0);
      afull_q  <= (count_next >= AFULL_C);
      aempty_q <= (count_next <= AEMPTY_C);
      if (bus.flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_ok) wptr <= wptr + 1'b1;
        if (rd_ok) rptr <= rptr + 1'b1;
      end
    end
  end

  // Error flags ignore flush; a new error in the clearing cycle stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.winc & wfull_q)  ovf_q <= 1'b1;
      else if (bus.clr_err)    ovf_q <= 1'b0;
      if (bus.rinc & rempty_q) unf_q <= 1'b1;
      else if (bus.clr_err)    unf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok & ~bus.flush) mem[wptr] <= bus.wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Storage is not reset, so mask the head while empty to keep rdata defined.
      assign bus.rdata = rempty_q ? '0 : mem[rptr];
    end else begin : g_reg_read
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  rdata_q <= '0;
        else if (rd_ok & ~bus.flush) rdata_q <= mem[rptr];
      end
      assign bus.rdata = rdata_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.wfull        = wfull_q;
  assign bus.rempty       = rempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives identical traffic into an FWFT and a registered-read FIFO and
// compares both against a queue-based reference model.
module tb_sync_fifo_flags;
  logic clk, rst_n;
  logic flush, winc, rinc, clr_err;
  logic [7:0] wdata;

  sync_fifo_flags_if #(.DSIZE(8), .ASIZE(4)) if1 ();
  sync_fifo_flags_if #(.DSIZE(8), .ASIZE(4)) if0 ();

  assign if1.flush = flush;  assign if0.flush = flush;
  assign if1.winc = winc;    assign if0.winc = winc;
  assign if1.wdata = wdata;  assign if0.wdata = wdata;
  assign if1.rinc = rinc;    assign if0.rinc = rinc;
  assign if1.clr_err = clr_err; assign if0.clr_err = clr_err;

  sync_fifo_flags #(.FWFT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  sync_fifo_flags #(.FWFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_rd0;

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_rd0 = 8'h00;
  endtask

  task automatic model_edge();
    bit full, empty;
    full  = (q.size() == 16);
    empty = (q.size() == 0);
    if (winc && full) m_ovf = 1; else if (clr_err) m_ovf = 0;
    if (rinc && empty) m_unf = 1; else if (clr_err) m_unf = 0;
    if (flush) q.delete();
    else begin
      if (rinc && !empty) m_rd0 = q.pop_front();
      if (winc && !full) q.push_back(wdata);
    end
  endtask

  task automatic cyc(input bit f, input bit w, input bit r, input bit c, input logic [7:0] d);
    flush = f; winc = w; rinc = r; clr_err = c; wdata = d;
    @(posedge clk);
    model_edge();
    #1;
    flush = 0; winc = 0; rinc = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; winc = 0; rinc = 0; clr_err = 0; wdata = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (if1.count !== 5'd0 || if1.rempty !== 1'b1 || if1.almost_empty !== 1'b1 || if1.wfull !== 1'b0 ||
        if1.almost_full !== 1'b0 || if1.overflow !== 1'b0 || if1.underflow !== 1'b0 || if1.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_fwft: count=%0d re=%b ae=%b wf=%b af=%b ov=%b un=%b rd=%h, required 0 1 1 0 0 0 0 00",
               if1.count, if1.rempty, if1.almost_empty, if1.wfull, if1.almost_full, if1.overflow, if1.underflow, if1.rdata);
    end
    n_checks++;
    if (if0.count !== 5'd0 || if0.rempty !== 1'b1 || if0.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_reg: count=%0d re=%b rd=%h, required 0 1 00", if0.count, if0.rempty, if0.rdata);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 0, 8'(i));
      n_checks++;
      if (if1.count !== 5'(i+1) || if1.almost_full !== (i+1 >= 12) || if1.wfull !== (i == 15) ||
          if1.rempty !== 1'b0 || if1.rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL fill[%0d]: count=%0d af=%b wf=%b re=%b rd=%h, required %0d %b %b 0 00",
                 i, if1.count, if1.almost_full, if1.wfull, if1.rempty, if1.rdata, i+1, (i+1 >= 12), (i == 15));
      end
    end
  endtask

  task automatic test_full_rw();
    cyc(0, 1, 1, 0, 8'hEE);
    n_checks++;
    if (if1.overflow !== 1'b1 || if1.count !== 5'd15 || if1.wfull !== 1'b0 || if1.rdata !== 8'h01) begin
      n_fail++;
      $display("FAIL full_rw: ov=%b count=%0d wf=%b rd=%h, required 1 15 0 01",
               if1.overflow, if1.count, if1.wfull, if1.rdata);
    end
    n_checks++;
    if (if0.rdata !== 8'h00 || if0.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rw_reg: rd=%h ov=%b, required 00 1", if0.rdata, if0.overflow);
    end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 15; k++) begin
      cyc(0, 0, 1, 0, 8'h00);
      n_checks++;
      if (if0.rdata !== 8'(k) || if1.count !== 5'(15-k) || if1.rempty !== (k == 15)) begin
        n_fail++;
        $display("FAIL drain[%0d]: rd_reg=%h count=%0d re=%b, required %h %0d %b",
                 k, if0.rdata, if1.count, if1.rempty, 8'(k), 15-k, (k == 15));
      end
    end
    cyc(0, 0, 1, 0, 8'h00);
    n_checks++;
    if (if1.underflow !== 1'b1 || if1.rempty !== 1'b1 || if1.count !== 5'd0 || if0.rdata !== 8'h0F) begin
      n_fail++;
      $display("FAIL underflow: un=%b re=%b count=%0d rd_reg=%h, required 1 1 0 0f",
               if1.underflow, if1.rempty, if1.count, if0.rdata);
    end
    cyc(0, 0, 0, 1, 8'h00);
    n_checks++;
    if (if1.underflow !== 1'b0 || if1.overflow !== 1'b0 || if0.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: un=%b ov=%b, required 0 0", if1.underflow, if1.overflow);
    end
    // clear and set in the same cycle: set must win
    cyc(0, 0, 1, 1, 8'h00);
    n_checks++;
    if (if1.underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_set: un=%b, required 1", if1.underflow);
    end
    cyc(0, 0, 0, 1, 8'h00);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, 1, 0, 8'($urandom));
      n_checks++;
      if (if1.count !== 5'd3 || if1.rdata !== q[0] || if0.rdata !== m_rd0 ||
          if1.overflow !== 1'b0 || if1.underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL stream[%0d]: count=%0d rd=%h rd_reg=%h ov=%b un=%b, required 3 %h %h 0 0",
                 i, if1.count, if1.rdata, if0.rdata, if1.overflow, if1.underflow, q[0], m_rd0);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 8'h50 + 8'(i));
    n_checks++;
    if (if1.count !== 5'd7) begin
      n_fail++;
      $display("FAIL pre_flush: count=%0d, required 7", if1.count);
    end
    cyc(1, 1, 0, 0, 8'h99);
    n_checks++;
    if (if1.count !== 5'd0 || if1.rempty !== 1'b1 || if1.almost_empty !== 1'b1 ||
        if1.almost_full !== 1'b0 || if0.rdata !== m_rd0) begin
      n_fail++;
      $display("FAIL flush: count=%0d re=%b ae=%b af=%b rd_reg=%h, required 0 1 1 0 %h",
               if1.count, if1.rempty, if1.almost_empty, if1.almost_full, if0.rdata, m_rd0);
    end
    cyc(0, 1, 0, 0, 8'h3C);
    n_checks++;
    if (if1.rdata !== 8'h3C || if1.count !== 5'd1) begin
      n_fail++;
      $display("FAIL post_flush: rd=%h count=%0d, required 3c 1", if1.rdata, if1.count);
    end
    cyc(0, 0, 1, 0, 8'h00);
    n_checks++;
    if (if0.rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL post_flush_reg: rd_reg=%h, required 3c", if0.rdata);
    end
  endtask

  task automatic test_reg_read();
    cyc(0, 1, 0, 0, 8'hA5);
    n_checks++;
    if (if0.rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL reg_before_rinc: rd_reg=%h, required 3c", if0.rdata);
    end
    cyc(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (if0.rdata !== 8'hA5) begin
        n_fail++;
        $display("FAIL reg_hold[%0d]: rd_reg=%h, required a5", i, if0.rdata);
      end
      cyc(0, 0, 0, 0, 8'h00);
    end
  endtask

  task automatic test_random();
    bit w, r, f, c;
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 5);
      cyc(f, w, r, c, 8'($urandom));
      n_checks++;
      if (if1.count !== 5'(q.size()) || if1.rempty !== (q.size() == 0) || if1.wfull !== (q.size() == 16) ||
          if1.almost_full !== (q.size() >= 12) || if1.almost_empty !== (q.size() <= 2) ||
          if1.overflow !== m_ovf || if1.underflow !== m_unf || if0.rdata !== m_rd0 ||
          (q.size() != 0 && if1.rdata !== q[0])) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%0d ov=%b un=%b rd=%h rd_reg=%h, required count=%0d ov=%b un=%b rd_reg=%h",
                 i, if1.count, if1.overflow, if1.underflow, if1.rdata, if0.rdata, q.size(), m_ovf, m_unf, m_rd0);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cyc(0, 1, i > 2, 0, 8'($urandom));
    cyc(0, 1, 1, 0, 8'h11);
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (if1.count !== 5'd0 || if1.rempty !== 1'b1 || if1.overflow !== 1'b0 || if0.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d re=%b ov=%b rd_reg=%h, required 0 1 0 00",
               if1.count, if1.rempty, if1.overflow, if0.rdata);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc(0, 1, 0, 0, 8'h77);
    n_checks++;
    if (if1.rdata !== 8'h77 || if1.count !== 5'd1) begin
      n_fail++;
      $display("FAIL after_reset: rd=%h count=%0d, required 77 1", if1.rdata, if1.count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_rw();
    test_drain();
    test_stream();
    test_flush();
    test_reg_read();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
